// File: rtl/alu_operand_seq.sv
// Operand-entry sequencer feeding the 4-bit ALU: synchronised, debounced
// buttons step a 4-state FSM that captures A, B and op from the switches.
module alu_operand_seq #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw,
   input  logic [2:0] op_sw,
   input  logic       btn_next,
   input  logic       btn_clr,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [2:0] op,
   output logic       valid,
   output logic [1:0] state,
   output logic [7:0] op_count
);

   localparam int unsigned CW = 16;
   localparam int unsigned NB = 2;

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_OP   = 2'd2,
      S_SHOW = 2'd3
   } state_t;

   state_t cur, nxt;

   // Index 0 is the next button, index 1 the clear button.
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] sync1, sync2, deb, deb_q, pulse;
   logic [CW-1:0] cnt [NB];

   logic [3:0] a_nxt, b_nxt;
   logic [2:0] op_nxt;
   logic       valid_nxt;
   logic [7:0] op_count_nxt;
   logic       next_pulse, clr_pulse;

   assign btn_raw = {btn_clr, btn_next};

   // Synchroniser, debounce counter and edge-detect history for both buttons.
   // A level is accepted on the first differing sample after the counter has
   // already reached DEBOUNCE_CYCLES.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < NB; i++) cnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < NB; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign pulse      = deb & ~deb_q;
   assign next_pulse = pulse[0];
   assign clr_pulse  = pulse[1];

   // FSM state and captured operand registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur      <= S_A;
         a        <= '0;
         b        <= '0;
         op       <= '0;
         valid    <= 1'b0;
         op_count <= '0;
      end else begin
         cur      <= nxt;
         a        <= a_nxt;
         b        <= b_nxt;
         op       <= op_nxt;
         valid    <= valid_nxt;
         op_count <= op_count_nxt;
      end
   end

   // Next-state and capture logic; clear overrides a coincident next press.
   always_comb begin
      nxt          = cur;
      a_nxt        = a;
      b_nxt        = b;
      op_nxt       = op;
      valid_nxt    = valid;
      op_count_nxt = op_count;
      if (clr_pulse) begin
         nxt          = S_A;
         a_nxt        = '0;
         b_nxt        = '0;
         op_nxt       = '0;
         valid_nxt    = 1'b0;
         op_count_nxt = '0;
      end else if (next_pulse) begin
         case (cur)
            S_A: begin
               a_nxt = sw;
               nxt   = S_B;
            end
            S_B: begin
               b_nxt = sw;
               nxt   = S_OP;
            end
            S_OP: begin
               op_nxt       = op_sw;
               valid_nxt    = 1'b1;
               op_count_nxt = op_count + 8'd1;
               nxt          = S_SHOW;
            end
            S_SHOW: begin
               valid_nxt = 1'b0;
               nxt       = S_A;
            end
            default: nxt = S_A;
         endcase
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed self-checking bench for alu_operand_seq with DEBOUNCE_CYCLES = 4.
module tb_alu_operand_seq;

   localparam int unsigned DEB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw;
   logic [2:0] op_sw;
   logic       btn_next;
   logic       btn_clr;
   logic [3:0] a;
   logic [3:0] b;
   logic [2:0] op;
   logic       valid;
   logic [1:0] state;
   logic [7:0] op_count;

   int total = 0;
   int bad   = 0;

   alu_operand_seq #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw),
      .op_sw    (op_sw),
      .btn_next (btn_next),
      .btn_clr  (btn_clr),
      .a        (a),
      .b        (b),
      .op       (op),
      .valid    (valid),
      .state    (state),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One debounced press and debounced release of the next button.
   task automatic press_next();
      btn_next = 1'b1;
      step(10);
      btn_next = 1'b0;
      step(12);
   endtask

   task automatic press_clr();
      btn_clr = 1'b1;
      step(10);
      btn_clr = 1'b0;
      step(12);
   endtask

   task automatic chk_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                          input logic [2:0] eop, input logic ev, input logic [1:0] es,
                          input logic [7:0] ec);
      chk({tag, ".a"}, 32'(a), 32'(ea));
      chk({tag, ".b"}, 32'(b), 32'(eb));
      chk({tag, ".op"}, 32'(op), 32'(eop));
      chk({tag, ".valid"}, 32'(valid), 32'(ev));
      chk({tag, ".state"}, 32'(state), 32'(es));
      chk({tag, ".op_count"}, 32'(op_count), 32'(ec));
   endtask

   initial begin
      rst      = 1'b1;
      sw       = 4'h0;
      op_sw    = 3'h0;
      btn_next = 1'b0;
      btn_clr  = 1'b0;

      // Reset with idle buttons.
      step(2);
      chk_all("reset", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0, 8'd0);

      // Button held through reset: one capture, 8th edge after release.
      sw       = 4'hA;
      btn_next = 1'b1;
      step(3);
      chk("rst_held.in_reset", 32'(state), 32'd0);
      rst = 1'b0;
      step(7);
      chk("rst_held.early_state", 32'(state), 32'd0);
      chk("rst_held.early_a", 32'(a), 32'h0);
      step(1);
      chk("rst_held.state", 32'(state), 32'd1);
      chk("rst_held.a", 32'(a), 32'hA);
      step(30);
      chk("rst_held.once", 32'(state), 32'd1);
      btn_next = 1'b0;
      step(12);

      // Full entry sequence with exact first-capture latency.
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
      sw       = 4'h5;
      btn_next = 1'b1;
      step(7);
      chk("lat.before", 32'(a), 32'h0);
      step(1);
      chk("lat.after", 32'(a), 32'h5);
      chk("lat.state", 32'(state), 32'd1);
      step(2);
      btn_next = 1'b0;
      step(12);
      sw = 4'h3;
      press_next();
      chk("seq.b_state", 32'(state), 32'd2);
      op_sw = 3'b001;
      press_next();
      chk_all("seq", 4'h5, 4'h3, 3'h1, 1'b1, 2'd3, 8'd1);

      // Three-cycle glitch changes nothing.
      btn_next = 1'b1;
      step(3);
      btn_next = 1'b0;
      step(20);
      chk_all("glitch", 4'h5, 4'h3, 3'h1, 1'b1, 2'd3, 8'd1);

      // Leave S_SHOW: valid drops, operands retained.
      press_next();
      chk_all("show_exit", 4'h5, 4'h3, 3'h1, 1'b0, 2'd0, 8'd1);

      // Button held 200 cycles advances exactly once.
      sw       = 4'h7;
      btn_next = 1'b1;
      step(200);
      btn_next = 1'b0;
      step(12);
      chk("held.state", 32'(state), 32'd1);
      chk("held.a", 32'(a), 32'h7);

      // Switch isolation in S_B.
      for (int i = 0; i < 6; i++) begin
         sw = 4'(i * 3 + 1);
         step(5);
      end
      chk("iso.a", 32'(a), 32'h7);
      chk("iso.b", 32'(b), 32'h3);
      chk("iso.state", 32'(state), 32'd1);
      sw       = 4'h9;
      btn_next = 1'b1;
      step(6);
      sw = 4'h6;
      step(1);
      chk("iso.pre_capture", 32'(b), 32'h3);
      step(1);
      sw = 4'hF;
      step(2);
      btn_next = 1'b0;
      step(12);
      chk("iso.b_capture", 32'(b), 32'h6);
      chk("iso.state2", 32'(state), 32'd2);

      // Clear and next pressed together in S_OP: clear wins.
      btn_next = 1'b1;
      btn_clr  = 1'b1;
      step(10);
      btn_next = 1'b0;
      btn_clr  = 1'b0;
      step(12);
      chk_all("clr_op", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0, 8'd0);

      // Clear in S_SHOW.
      sw = 4'h2;
      press_next();
      sw = 4'h4;
      press_next();
      op_sw = 3'b110;
      press_next();
      chk_all("pre_clr_show", 4'h2, 4'h4, 3'h6, 1'b1, 2'd3, 8'd1);
      press_clr();
      chk_all("clr_show", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0, 8'd0);

      // 256 complete entry cycles: op_count wraps to 0.
      for (int i = 1; i <= 256; i++) begin
         sw = 4'(i);
         press_next();
         press_next();
         op_sw = 3'(i);
         press_next();
         chk("wrap.valid_set", 32'(valid), 32'd1);
         if (i == 255) chk("wrap.count255", 32'(op_count), 32'd255);
         if (i == 256) chk("wrap.count0", 32'(op_count), 32'd0);
         press_next();
         chk("wrap.valid_clr", 32'(valid), 32'd0);
      end
      chk("wrap.state", 32'(state), 32'd0);
      chk("wrap.op", 32'(op), 32'(3'(256)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
